// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the PC, streams sequential ROM reads and buffers the
// returned words in a small FIFO that feeds the decoder over a valid/ready handshake.
module instr_fetch_queue #(
   parameter int              PC_W     = 64,
   parameter int              INSTR_W  = 32,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic [PC_W-1:0]          rom_addr,
   output logic                     rom_req,
   input  logic [INSTR_W-1:0]       rom_data,
   input  logic                     branch_taken,
   input  logic [PC_W-1:0]          branch_target,
   output logic [INSTR_W-1:0]       instr_out,
   output logic [PC_W-1:0]          instr_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_W-1:0]    pc_q, pc_d;
   logic               inflight_q, inflight_d;
   logic [PC_W-1:0]    reqAddr_q, reqAddr_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [INSTR_W-1:0] lastInstr_q, lastInstr_d;
   logic [PC_W-1:0]    lastPc_q, lastPc_d;

   logic [INSTR_W-1:0] memInstr [DEPTH];
   logic [PC_W-1:0]    memPc    [DEPTH];

   logic               issue;
   logic               push;
   logic               pop;
   logic [CNT_W-1:0]   credit;
   logic [PC_W-1:0]    alignedTarget;

   assign alignedTarget = branch_target & ~PC_W'(3);
   assign credit        = count_q + CNT_W'(inflight_q);

   // Credits count the in-flight read so a returning word always has a free slot.
   assign issue = !reset && !branch_taken && (credit < CNT_W'(DEPTH));

   // A read in flight across a redirect edge is dropped rather than pushed.
   assign push  = inflight_q && !branch_taken;
   assign pop   = instr_valid && instr_ready;

   assign instr_valid = (count_q != '0);
   assign rom_req     = issue;
   assign rom_addr    = pc_q;
   assign occupancy   = count_q;
   assign instr_out   = instr_valid ? memInstr[head_q] : lastInstr_q;
   assign instr_pc    = instr_valid ? memPc[head_q]    : lastPc_q;

   always_comb begin
      pc_d        = pc_q;
      inflight_d  = issue;
      reqAddr_d   = reqAddr_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      lastInstr_d = lastInstr_q;
      lastPc_d    = lastPc_q;

      if (instr_valid) begin
         lastInstr_d = memInstr[head_q];
         lastPc_d    = memPc[head_q];
      end

      if (issue) begin
         reqAddr_d = pc_q;
         pc_d      = pc_q + PC_W'(4);
      end

      if (branch_taken) begin
         pc_d    = alignedTarget;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         if (push) begin
            tail_d = tail_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         inflight_q  <= 1'b0;
         reqAddr_q   <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         lastInstr_q <= '0;
         lastPc_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         inflight_q  <= inflight_d;
         reqAddr_q   <= reqAddr_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         lastInstr_q <= lastInstr_d;
         lastPc_q    <= lastPc_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clock) begin
      if (push) begin
         memInstr[tail_q] <= rom_data;
         memPc[tail_q]    <= reqAddr_q;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a one-cycle-latency ROM returns word[i] = i for
// byte address 4*i, and each step checks the fetch/queue outputs against hand-computed values.
module tb_instr_fetch_queue;

   logic        clock;
   logic        reset;
   logic [63:0] rom_addr;
   logic        rom_req;
   logic [31:0] rom_data;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [31:0] instr_out;
   logic [63:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  occupancy;

   int testsRun  = 0;
   int failCount = 0;

   logic arm8  = 1'b0;
   logic arm40 = 1'b0;
   int   pops8  = 0;
   int   seen40 = 0;

   instr_fetch_queue dut (
      .clock         (clock),
      .reset         (reset),
      .rom_addr      (rom_addr),
      .rom_req       (rom_req),
      .rom_data      (rom_data),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .occupancy     (occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ROM model answers one cycle after the request; idle cycles return a poison word.
   always @(posedge clock) begin
      if (rom_req) rom_data <= rom_addr[33:2];
      else         rom_data <= 32'hDEAD_BEEF;
   end

   always @(posedge clock) begin
      if (arm8 && instr_valid && instr_ready && instr_pc == 64'h8) pops8 <= pops8 + 1;
      if (arm40 && instr_valid && instr_pc == 64'h40) seen40 <= seen40 + 1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, expected $finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic rst, input logic ready, input logic br,
                                input logic [63:0] target);
      reset         = rst;
      instr_ready   = ready;
      branch_taken  = br;
      branch_target = target;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rom_data = 32'hDEAD_BEEF;
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
      tick();
      tick();
      checkOutput("rst_req",   64'(rom_req),     64'h0);
      checkOutput("rst_valid", 64'(instr_valid), 64'h0);
      checkOutput("rst_occ",   64'(occupancy),   64'h0);
      checkOutput("rst_out",   64'(instr_out),   64'h0);
      checkOutput("rst_pc",    instr_pc,         64'h0);

      // Straight-line streaming at one instruction per cycle.
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
      checkOutput("t1_req0",  64'(rom_req), 64'h1);
      checkOutput("t1_addr0", rom_addr,     64'h0);
      tick();
      checkOutput("t1_valid_e1", 64'(instr_valid), 64'h0);
      tick();
      for (int i = 0; i < 6; i++) begin
         checkOutput("t1_valid", 64'(instr_valid), 64'h1);
         checkOutput("t1_pc",    instr_pc,         64'(4 * i));
         checkOutput("t1_out",   64'(instr_out),   64'(i));
         checkOutput("t1_occ",   64'(occupancy),   64'h1);
         tick();
      end

      // Decoder stalls: queue fills to DEPTH, then drains with no gap.
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("t2_occ",   64'(occupancy),   64'h4);
      checkOutput("t2_req",   64'(rom_req),     64'h0);
      checkOutput("t2_valid", 64'(instr_valid), 64'h1);
      checkOutput("t2_head",  instr_pc,         64'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
      for (int i = 0; i < 6; i++) begin
         checkOutput("t2_valid_d", 64'(instr_valid), 64'h1);
         checkOutput("t2_pc",      instr_pc,         64'(4 * i));
         checkOutput("t2_out",     64'(instr_out),   64'(i));
         tick();
      end

      // Flush with three queued entries and one read in flight.
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("t3_occ_pre", 64'(occupancy), 64'h3);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h100);
      checkOutput("t3_req_flush", 64'(rom_req), 64'h0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
      checkOutput("t3_occ_post", 64'(occupancy),   64'h0);
      checkOutput("t3_valid0",   64'(instr_valid), 64'h0);
      checkOutput("t3_hold_pc",  instr_pc,         64'h0);
      checkOutput("t3_req",      64'(rom_req),     64'h1);
      checkOutput("t3_addr",     rom_addr,         64'h100);
      tick();
      checkOutput("t3_valid1", 64'(instr_valid), 64'h0);
      tick();
      checkOutput("t3_valid2", 64'(instr_valid), 64'h1);
      checkOutput("t3_pc",     instr_pc,         64'h100);
      checkOutput("t3_out",    64'(instr_out),   64'h40);

      // Flush coinciding with the pop of 0x8; misaligned target is realigned.
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
      arm8 = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checkOutput("t4_head8", instr_pc, 64'h8);
      applyStimulus(1'b0, 1'b1, 1'b1, 64'h203);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
      checkOutput("t4_addr", rom_addr, 64'h200);
      tick();
      checkOutput("t4_valid1", 64'(instr_valid), 64'h0);
      tick();
      checkOutput("t4_valid2", 64'(instr_valid), 64'h1);
      checkOutput("t4_pc",     instr_pc,         64'h200);
      checkOutput("t4_out",    64'(instr_out),   64'h80);
      checkOutput("t4_pops8",  64'(pops8),       64'h1);
      arm8 = 1'b0;

      // Back-to-back flushes: only the second target is fetched.
      arm40 = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b1, 64'h40);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 64'h80);
      checkOutput("t5_req_flush2", 64'(rom_req), 64'h0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
      checkOutput("t5_addr",   rom_addr,         64'h80);
      checkOutput("t5_valid0", 64'(instr_valid), 64'h0);
      tick();
      checkOutput("t5_valid1", 64'(instr_valid), 64'h0);
      tick();
      checkOutput("t5_valid2", 64'(instr_valid), 64'h1);
      checkOutput("t5_pc",     instr_pc,         64'h80);
      checkOutput("t5_out",    64'(instr_out),   64'h20);
      tick();
      checkOutput("t5_pc_next", instr_pc,       64'h84);
      checkOutput("t5_seen40",  64'(seen40),    64'h0);
      arm40 = 1'b0;

      // Reset mid-stream with three entries queued.
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      tick();
      tick();
      checkOutput("t6_occ_pre", 64'(occupancy), 64'h3);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
      checkOutput("t6_req",   64'(rom_req),     64'h0);
      checkOutput("t6_valid", 64'(instr_valid), 64'h0);
      checkOutput("t6_occ",   64'(occupancy),   64'h0);
      checkOutput("t6_out",   64'(instr_out),   64'h0);
      checkOutput("t6_pc",    instr_pc,         64'h0);
      checkOutput("t6_addr",  rom_addr,         64'h0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
      checkOutput("t6_restart_req",  64'(rom_req), 64'h1);
      checkOutput("t6_restart_addr", rom_addr,     64'h0);
      tick();
      checkOutput("t6_valid1", 64'(instr_valid), 64'h0);
      tick();
      checkOutput("t6_valid2", 64'(instr_valid), 64'h1);
      checkOutput("t6_pc0",    instr_pc,         64'h0);
      checkOutput("t6_out0",   64'(instr_out),   64'h0);
      checkOutput("t6_occ1",   64'(occupancy),   64'h1);
      tick();
      checkOutput("t6_pc4", instr_pc, 64'h4);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
